// File: rtl/dmem_pkg.sv
// dmem_pkg: shared length encodings, FSM states and defaults for the data-memory arbiter
package dmem_pkg;
  localparam int DEF_MEM_BYTES = 100;
  localparam logic [1:0] LEN_NONE = 2'b00;
  localparam logic [1:0] LEN_BYTE = 2'b01;
  localparam logic [1:0] LEN_HALF = 2'b10;
  localparam logic [1:0] LEN_WORD = 2'b11;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    return len == LEN_WORD ? 3'd4 : len == LEN_HALF ? 3'd2 : len == LEN_BYTE ? 3'd1 : 3'd0;
  endfunction
endpackage

// File: rtl/dmem_rr_arbiter.sv
// dmem_rr_arbiter: two-requester round-robin, one-hot grant; last=1 means P1 was granted last
module dmem_rr_arbiter (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);
  always_comb grant = req == 2'b11 ? (last ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port front end sharing one data memory, one access per three cycles
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int MEM_BYTES = DEF_MEM_BYTES,
  parameter int ADDR_W    = 32
) (
  input  logic              SYS_clk,
  input  logic              SYS_reset_n,
  input  logic              P0_req,
  input  logic              P0_we,
  input  logic [1:0]        P0_length,
  input  logic              P0_signed,
  input  logic [ADDR_W-1:0] P0_addr,
  input  logic [ADDR_W-1:0] P0_wdata,
  output logic              P0_ack,
  output logic [ADDR_W-1:0] P0_rdata,
  output logic              P0_err,
  input  logic              P1_req,
  input  logic              P1_we,
  input  logic [1:0]        P1_length,
  input  logic              P1_signed,
  input  logic [ADDR_W-1:0] P1_addr,
  input  logic [ADDR_W-1:0] P1_wdata,
  output logic              P1_ack,
  output logic [ADDR_W-1:0] P1_rdata,
  output logic              P1_err,
  output logic [1:0]        MEM_read_length,
  output logic [1:0]        MEM_write_length,
  output logic              MEM_read_signed,
  output logic [ADDR_W-1:0] MEM_read_address,
  output logic [ADDR_W-1:0] MEM_write_address,
  output logic [ADDR_W-1:0] MEM_write_data,
  input  logic [ADDR_W-1:0] MEM_read_data
);
  state_t state;
  logic last, l_idx, l_we, l_err;
  logic [1:0] grant;
  logic win, w_we, w_sgn, w_err, go, wr, rd, done0, done1;
  logic [1:0] w_len;
  logic [ADDR_W-1:0] w_addr, w_wdata, rdata;
  logic [ADDR_W:0] w_end;
  dmem_rr_arbiter u_rr (.req({P1_req, P0_req}), .last(last), .grant(grant));
  // rd/wr launch the memory cycle from IDLE so MEM_* is live exactly during BUSY
  always_comb begin
    win     = grant[1];
    w_we    = win ? P1_we : P0_we;
    w_len   = win ? P1_length : P0_length;
    w_sgn   = win ? P1_signed : P0_signed;
    w_addr  = win ? P1_addr : P0_addr;
    w_wdata = win ? P1_wdata : P0_wdata;
    w_end   = {1'b0, w_addr} + (ADDR_W+1)'(len_bytes(w_len));
    w_err   = w_len == LEN_NONE || (w_len == LEN_HALF && w_addr[0]) ||
              (w_len == LEN_WORD && w_addr[1:0] != 2'b00) || w_end > (ADDR_W+1)'(MEM_BYTES);
    go      = state == IDLE && |grant;
    wr      = go && !w_err && w_we;
    rd      = go && !w_err && !w_we;
    done0   = state == BUSY && !l_idx;
    done1   = state == BUSY && l_idx;
    rdata   = !l_we && !l_err ? MEM_read_data : '0;
  end
  always_ff @(posedge SYS_clk or negedge SYS_reset_n)
    if (!SYS_reset_n) begin
      state             <= IDLE;
      last              <= 1'b1;
      l_idx             <= 1'b0;
      l_we              <= 1'b0;
      l_err             <= 1'b0;
      MEM_write_length  <= LEN_NONE;
      MEM_write_address <= '0;
      MEM_write_data    <= '0;
      MEM_read_length   <= LEN_NONE;
      MEM_read_signed   <= 1'b0;
      MEM_read_address  <= '0;
      P0_ack            <= 1'b0;
      P1_ack            <= 1'b0;
      P0_err            <= 1'b0;
      P1_err            <= 1'b0;
      P0_rdata          <= '0;
      P1_rdata          <= '0;
    end else begin
      state <= state == IDLE ? (go ? BUSY : IDLE) : state == BUSY ? DONE : IDLE;
      if (go) begin
        last  <= win;
        l_idx <= win;
        l_we  <= w_we;
        l_err <= w_err;
      end
      MEM_write_length  <= wr ? w_len : LEN_NONE;
      MEM_write_address <= wr ? w_addr : '0;
      MEM_write_data    <= wr ? w_wdata : '0;
      MEM_read_length   <= rd ? w_len : LEN_NONE;
      MEM_read_signed   <= rd && w_sgn;
      MEM_read_address  <= rd ? w_addr : '0;
      P0_ack            <= done0;
      P1_ack            <= done1;
      P0_err            <= done0 && l_err;
      P1_err            <= done1 && l_err;
      P0_rdata          <= done0 ? rdata : '0;
      P1_rdata          <= done1 ? rdata : '0;
    end
endmodule
